// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone interconnect.
// Contents:
//   state_t      FSM states (IDLE, FWD, ERR)
//   slv_idx_t    2-bit slave index
//   NUM_SLAVES   number of downstream slaves
//   S*_BASE_DEF  default base address of each slave region
//   S*_SIZE_DEF  default size in bytes of each slave region (powers of two)
package wb_pkg;

  localparam int unsigned NUM_SLAVES = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ERR  = 2'd2
  } state_t;

  typedef logic [1:0] slv_idx_t;

  localparam logic [31:0] S0_BASE_DEF = 32'h1000_0000;  // flash
  localparam logic [31:0] S0_SIZE_DEF = 32'h0020_0000;
  localparam logic [31:0] S1_BASE_DEF = 32'h2000_0000;  // memory
  localparam logic [31:0] S1_SIZE_DEF = 32'h0001_0000;
  localparam logic [31:0] S2_BASE_DEF = 32'h3000_0000;  // control
  localparam logic [31:0] S2_SIZE_DEF = 32'h0000_0100;

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder for a three-region Wishbone address map.
// Ports:
//   adr  in   32  byte address to decode
//   hit  out  1   address falls inside at least one region
//   idx  out  2   index of the matching region; lowest index wins on overlap,
//                 0 when nothing matches
module wb_addr_decoder
  import wb_pkg::*;
#(
  parameter logic [31:0] S0_BASE = S0_BASE_DEF,
  parameter logic [31:0] S0_SIZE = S0_SIZE_DEF,
  parameter logic [31:0] S1_BASE = S1_BASE_DEF,
  parameter logic [31:0] S1_SIZE = S1_SIZE_DEF,
  parameter logic [31:0] S2_BASE = S2_BASE_DEF,
  parameter logic [31:0] S2_SIZE = S2_SIZE_DEF
) (
  input  logic [31:0] adr,
  output logic        hit,
  output slv_idx_t    idx
);

  logic [NUM_SLAVES-1:0] hits;

  // Region sizes are powers of two, so masking off the offset bits leaves the base.
  assign hits[0] = (adr & ~(S0_SIZE - 32'd1)) == S0_BASE;
  assign hits[1] = (adr & ~(S1_SIZE - 32'd1)) == S1_BASE;
  assign hits[2] = (adr & ~(S2_SIZE - 32'd1)) == S2_BASE;

  assign hit = |hits;

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hits[i]) begin
        idx = slv_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, three-slave Wishbone classic interconnect.
// The request is registered in IDLE together with its decoded slave index; the
// selected slave then sees cyc/stb from the next cycle on and its response is
// muxed straight back to the master. Unmapped addresses produce a one-cycle
// bus error without touching any slave.
// Optional build macro WB_INTERCONNECT_TIMEOUT_EN adds a watchdog that turns a
// slave that never responds within TIMEOUT_CYCLES cycles into a bus error.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   m_cyc_i .. m_we_i          master request
//   m_dat_o, m_ack_o,
//   m_err_o, m_rty_o           response to master
//   s_cyc_o, s_stb_o [2:0]     per-slave cycle/strobe, bit n = slave n
//   s_adr_o .. s_we_o          latched request, shared by all slaves
//   s_dat_i [95:0]             slave read data, slave n at [32n+31:32n]
//   s_ack_i, s_err_i, s_rty_i  per-slave responses
module wb_interconnect
  import wb_pkg::*;
#(
  parameter logic [31:0] S0_BASE = S0_BASE_DEF,
  parameter logic [31:0] S0_SIZE = S0_SIZE_DEF,
  parameter logic [31:0] S1_BASE = S1_BASE_DEF,
  parameter logic [31:0] S1_SIZE = S1_SIZE_DEF,
  parameter logic [31:0] S2_BASE = S2_BASE_DEF,
  parameter logic [31:0] S2_SIZE = S2_SIZE_DEF
`ifdef WB_INTERCONNECT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic [31:0] m_adr_i,
  input  logic [3:0]  m_sel_i,
  input  logic [31:0] m_dat_i,
  input  logic        m_we_i,
  output logic [31:0] m_dat_o,
  output logic        m_ack_o,
  output logic        m_err_o,
  output logic        m_rty_o,
  output logic [2:0]  s_cyc_o,
  output logic [2:0]  s_stb_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  input  logic [95:0] s_dat_i,
  input  logic [2:0]  s_ack_i,
  input  logic [2:0]  s_err_i,
  input  logic [2:0]  s_rty_i
);

  state_t                state_q, state_d;
  slv_idx_t              idx_q, idx_d;
  logic [31:0]           adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic [3:0]            sel_q, sel_d;
  logic                  we_q, we_d;

  logic                  dec_hit;
  slv_idx_t              dec_idx;
  logic                  req;
  logic                  resp;
  logic                  timeout;
  logic [NUM_SLAVES-1:0] slv_oh;
  logic [31:0]           slv_rdat;

  wb_addr_decoder #(
    .S0_BASE (S0_BASE),
    .S0_SIZE (S0_SIZE),
    .S1_BASE (S1_BASE),
    .S1_SIZE (S1_SIZE),
    .S2_BASE (S2_BASE),
    .S2_SIZE (S2_SIZE)
  ) u_decoder (
    .adr (m_adr_i),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  assign req    = m_cyc_i & m_stb_i;
  assign slv_oh = 3'b001 << idx_q;
  // Only the selected slave's responses count; the others are masked off.
  assign resp   = |((s_ack_i | s_err_i | s_rty_i) & slv_oh);

  always_comb begin
    slv_rdat = '0;
    unique case (idx_q)
      2'd0:    slv_rdat = s_dat_i[31:0];
      2'd1:    slv_rdat = s_dat_i[63:32];
      2'd2:    slv_rdat = s_dat_i[95:64];
      default: slv_rdat = '0;
    endcase
  end

  assign s_adr_o = adr_q;
  assign s_dat_o = dat_q;
  assign s_sel_o = sel_q;
  assign s_we_o  = we_q;

`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = cnt_q == CntW'(TIMEOUT_CYCLES - 1);

  // Held at zero outside FWD so every FWD entry starts from a clean count.
  always_comb begin
    cnt_d = '0;
    if (state_q == FWD && !resp) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    s_cyc_o = '0;
    s_stb_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_rty_o = 1'b0;
    m_dat_o = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = dec_idx;
          adr_d   = m_adr_i;
          dat_d   = m_dat_i;
          sel_d   = m_sel_i;
          we_d    = m_we_i;
          state_d = dec_hit ? FWD : ERR;
        end
      end
      FWD: begin
        if (!req) begin
          // Master abandoned the cycle: drop the slave strobe, answer nothing.
          state_d = IDLE;
        end else begin
          s_cyc_o = slv_oh;
          s_stb_o = slv_oh;
          m_ack_o = |(s_ack_i & slv_oh);
          m_err_o = |(s_err_i & slv_oh);
          m_rty_o = |(s_rty_i & slv_oh);
          m_dat_o = slv_rdat;
          // A response in the limit cycle takes priority over the timeout.
          if (resp) begin
            state_d = IDLE;
          end else if (timeout) begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        m_err_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Self-checking bench for wb_interconnect. Each transfer pushes its expected
// response (kind, data, latency, strobe window) onto a scoreboard queue when the
// request is driven; the entry is popped and compared when the master sees a
// response. The bench plays both the master and the three slaves.
module tb_wb_interconnect;

  localparam logic [1:0]  K_ACK = 2'd1;
  localparam logic [1:0]  K_ERR = 2'd2;
  localparam logic [1:0]  K_RTY = 2'd3;
  localparam int          NEVER = 100000;
  localparam int          TO    = 8;
  localparam logic [95:0] JUNK  = {32'h5A5A_0002, 32'h5A5A_0001, 32'h5A5A_0000};

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
    int          lat;       // cycle index (request cycle = 0) of the response
    int          stb_last;  // last cycle index with the slave strobe high
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m_cyc_i, m_stb_i, m_we_i;
  logic [31:0] m_adr_i, m_dat_i;
  logic [3:0]  m_sel_i;
  logic [31:0] m_dat_o;
  logic        m_ack_o, m_err_o, m_rty_o;
  logic [2:0]  s_cyc_o, s_stb_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o;
  logic [95:0] s_dat_i;
  logic [2:0]  s_ack_i, s_err_i, s_rty_i;

  always #5 clk_i = ~clk_i;

  wb_interconnect #(
    .S0_BASE (32'h1000_0000)
`ifdef WB_INTERCONNECT_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_adr_i (m_adr_i),
    .m_sel_i (m_sel_i),
    .m_dat_i (m_dat_i),
    .m_we_i  (m_we_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_adr_o (s_adr_o),
    .s_sel_o (s_sel_o),
    .s_dat_o (s_dat_o),
    .s_we_o  (s_we_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .s_rty_i (s_rty_i)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference address map: fixed masks for each region, lowest index first.
  function automatic int ref_decode(input logic [31:0] a);
    if ((a & 32'hFFE0_0000) == 32'h1000_0000) return 0;
    if ((a & 32'hFFFF_0000) == 32'h2000_0000) return 1;
    if ((a & 32'hFFFF_FF00) == 32'h3000_0000) return 2;
    return -1;
  endfunction

  task automatic idle_bus();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    s_ack_i = '0;
    s_err_i = '0;
    s_rty_i = '0;
    s_dat_i = JUNK;
  endtask

  // One master transfer; the target slave answers with rkind/rdat once it has
  // seen its strobe for rlat cycles. noise_ack is held on the slave ack lines
  // throughout to exercise response masking.
  task automatic xfer(input string tag, input logic [31:0] adr, input logic we,
                      input logic [31:0] wdat, input logic [3:0] sel,
                      input logic [1:0] rkind, input int rlat, input logic [31:0] rdat,
                      input logic [2:0] noise_ack);
    int         tgt;
    int         cyc;
    int         stb_cnt;
    bit         done;
    exp_t       e;
    exp_t       g;
    logic [2:0] exp_stb;
    logic [1:0] got_kind;
    tgt = ref_decode(adr);
    if (tgt < 0)           e = '{K_ERR, 32'h0, 1, 0};
    else if (rlat >= NEVER) e = '{K_ERR, 32'h0, TO + 1, TO};
    else                   e = '{rkind, rdat, rlat + 1, rlat + 1};
    @(posedge clk_i); #1;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = adr;
    m_we_i  = we;
    m_dat_i = wdat;
    m_sel_i = sel;
    s_ack_i = noise_ack;
    exp_q.push_back(e);
    cyc = 0;
    stb_cnt = 0;
    done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk_i);
      exp_stb = (cyc >= 1 && cyc <= e.stb_last) ? 3'(3'b001 << tgt) : 3'b000;
      check_eq({tag, "_stb"}, s_stb_o, exp_stb);
      check_eq({tag, "_cyc"}, s_cyc_o, exp_stb);
      if (cyc == 1) begin
        check_eq({tag, "_s_adr"}, s_adr_o, adr);
        check_eq({tag, "_s_dat"}, s_dat_o, wdat);
        check_eq({tag, "_s_sel"}, s_sel_o, sel);
        check_eq({tag, "_s_we"}, s_we_o, we);
      end
      if (tgt >= 0 && s_stb_o[tgt]) stb_cnt++;
      if (m_ack_o || m_err_o || m_rty_o) begin
        done = 1'b1;
        got_kind = m_ack_o ? K_ACK : (m_err_o ? K_ERR : K_RTY);
        if (exp_q.size() == 0) begin
          check_eq({tag, "_unexpected_resp"}, 1, 0);
        end else begin
          g = exp_q.pop_front();
          check_eq({tag, "_onehot"}, $countones({m_ack_o, m_err_o, m_rty_o}), 1);
          check_eq({tag, "_kind"}, got_kind, g.kind);
          check_eq({tag, "_data"}, m_dat_o, g.data);
          check_eq({tag, "_latency"}, cyc, g.lat);
        end
      end
      @(posedge clk_i); #1;
      if (cyc == 0) begin
        // Master lines change after acceptance; the slaves must keep the latched copy.
        m_adr_i = ~adr;
        m_dat_i = ~wdat;
        m_sel_i = ~sel;
        m_we_i  = ~we;
      end
      cyc++;
      if (!done && tgt >= 0 && rlat < NEVER && stb_cnt >= rlat) begin
        s_dat_i[32*tgt +: 32] = rdat;
        if (rkind == K_ACK) s_ack_i[tgt] = 1'b1;
        if (rkind == K_ERR) s_err_i[tgt] = 1'b1;
        if (rkind == K_RTY) s_rty_i[tgt] = 1'b1;
      end
    end
    if (!done) begin
      check_eq({tag, "_resp_timeout"}, cyc, e.lat);
      void'(exp_q.pop_front());
    end
    idle_bus();
    @(negedge clk_i);
    check_eq({tag, "_after"}, {m_ack_o, m_err_o, m_rty_o, s_stb_o, s_cyc_o}, 9'h0);
  endtask

  initial begin
    int hang_cnt;
    idle_bus();
    rst_i = 1'b1;
    // Requests and slave responses during reset must be ignored.
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = 32'h2000_0000;
    s_ack_i = 3'b111;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_resp", {m_ack_o, m_err_o, m_rty_o}, 3'b000);
    check_eq("rst_mdat", m_dat_o, 32'h0);
    check_eq("rst_strobes", {s_cyc_o, s_stb_o}, 6'h0);
    check_eq("rst_latched", {s_adr_o, s_dat_o, s_sel_o, s_we_o}, 69'h0);
    idle_bus();
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    xfer("rd_mem", 32'h2000_0010, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'hDEAD_BEEF, 3'b000);
    xfer("wr_ctl", 32'h3000_0004, 1'b1, 32'h1, 4'hF, K_ACK, 1, 32'h0, 3'b000);
    xfer("unmapped", 32'h4000_0000, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'h0, 3'b000);
    xfer("noise", 32'h1000_0000, 1'b0, 32'h0, 4'h3, K_ACK, 3, 32'h0BAD_F00D, 3'b010);
    xfer("slv_err", 32'h3000_00FC, 1'b1, 32'h55AA, 4'h1, K_ERR, 2, 32'h1234_5678, 3'b000);
    xfer("slv_rty", 32'h2000_8000, 1'b0, 32'h0, 4'hC, K_RTY, 1, 32'h8765_4321, 3'b000);
    xfer("s0_top", 32'h101F_FFFC, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'hA5A5_0000, 3'b000);
    xfer("s0_past", 32'h1020_0000, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'h0, 3'b000);
    xfer("s1_top", 32'h2000_FFFF, 1'b1, 32'h77, 4'h8, K_ACK, 1, 32'h0, 3'b000);
    xfer("s2_past", 32'h3000_0100, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'h0, 3'b000);

    // Reset pulsed while forwarding to slave 0.
    @(posedge clk_i); #1;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = 32'h1000_0000;
    m_sel_i = 4'hF;
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("rstfwd_stb", s_stb_o, 3'b001);
    #2;
    s_ack_i = 3'b001;
    rst_i = 1'b1;
    #1;
    check_eq("rstfwd_resp", {m_ack_o, m_err_o, m_rty_o}, 3'b000);
    check_eq("rstfwd_strobes", {s_cyc_o, s_stb_o}, 6'h0);
    check_eq("rstfwd_mdat", m_dat_o, 32'h0);
    check_eq("rstfwd_adr", s_adr_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle_bus();
    repeat (2) begin
      @(negedge clk_i);
      check_eq("rstfwd_quiet", {m_ack_o, m_err_o, m_rty_o, s_stb_o}, 6'h0);
    end
    xfer("post_rst", 32'h1000_0000, 1'b0, 32'h0, 4'hF, K_ACK, 2, 32'hCAFE_F00D, 3'b000);

    // Master drops its strobe mid-transfer while the slave acks.
    @(posedge clk_i); #1;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = 32'h2000_0040;
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("abort_stb_before", s_stb_o, 3'b010);
    #2;
    m_stb_i = 1'b0;
    s_ack_i = 3'b010;
    #1;
    check_eq("abort_strobes", {s_cyc_o, s_stb_o}, 6'h0);
    check_eq("abort_resp", {m_ack_o, m_err_o, m_rty_o}, 3'b000);
    @(posedge clk_i); #1;
    idle_bus();
    @(negedge clk_i);
    check_eq("abort_quiet", {m_ack_o, m_err_o, m_rty_o, s_stb_o}, 6'h0);
    xfer("post_abort", 32'h2000_0044, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'h0F0F_0F0F, 3'b000);

`ifdef WB_INTERCONNECT_TIMEOUT_EN
    xfer("timeout", 32'h2000_0000, 1'b0, 32'h0, 4'hF, K_ACK, NEVER, 32'h0, 3'b000);
`else
    // Without the watchdog a silent slave keeps the strobe up indefinitely.
    @(posedge clk_i); #1;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = 32'h2000_0000;
    hang_cnt = 0;
    for (int i = 0; i < 1001; i++) begin
      @(negedge clk_i);
      if (i >= 1 && s_stb_o == 3'b010 && !(m_ack_o || m_err_o || m_rty_o)) hang_cnt++;
    end
    check_eq("hang_stb_cycles", hang_cnt, 1000);
    @(posedge clk_i); #1;
    idle_bus();
    @(negedge clk_i);
    check_eq("hang_release", {m_ack_o, m_err_o, m_rty_o, s_stb_o}, 6'h0);
`endif

    check_eq("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
